pe_window_loader: RTL and testbench
===================================

PE_WINDOW_LOADER -- requirements
Module: pe_window_loader

Interface
REQ-001 SHALL have ports:
  clk  input  1  single clock, all state updates on rising edge
  rst_n  input  1  asynchronous active-low reset
  in_valid  input  1  sample offered
  in_data  input  2  2-bit input sample
  in_first  input  1  sample is first of a new row; qualifies in_valid
  in_ready  output  1  loader accepts a sample this cycle
  filt_valid  input  1  filter tap offered
  filt_data  input  2  2-bit filter tap
  filt_ready  output  1  loader accepts a filter tap this cycle
  win_valid  output  1  window and filter stable and presented to the PE
  win_ready  input  1  PE stage consumes the window
  win_data  output  24  12-sample window, sample k at bits [2k+1:2k], k=0 oldest
  filter  output  6  3-tap filter, tap t at bits [2t+1:2t]
  filt_loaded  output  1  all 3 taps of the current filter are valid

Function
REQ-002 SHALL accept a sample when in_valid and in_ready are both high in the same cycle.
REQ-003 SHALL accept a filter tap when filt_valid and filt_ready are both high in the same cycle.
REQ-004 SHALL keep a fill count cnt in the range 0..12 that counts the valid samples in the window.
REQ-005 SHALL use three fill states: EMPTY (cnt=0), FILL (1..11) and FULL (cnt=12).
REQ-006 SHALL drive in_ready = (cnt<12); there is no bypass, so in_ready stays low while FULL even when win_ready is high.
REQ-007 SHALL write an accepted sample (without in_first) into slot cnt and then increment cnt.
REQ-008 SHALL, on an accepted sample with in_first, discard all held samples, write the sample to slot 0 and set cnt=1, in every state except FULL.
REQ-009 SHALL drive win_valid = (cnt==12) AND filt_loaded.
REQ-010 SHALL hold win_data and filter stable while win_valid is high and win_ready is low.
REQ-011 SHALL, on the handshake (win_valid AND win_ready), move slots 10 and 11 into slots 0 and 1 and set cnt=2.
- Reason: this 2-sample overlap keeps the 3-tap convolution continuous across windows.
- Each following window therefore needs 10 new samples.
REQ-012 SHALL clear slots 2..11 to 0 on the handshake.
REQ-013 SHALL drive filt_ready = NOT win_valid, so the filter never changes under a presented window.
REQ-014 SHALL keep a tap index tcnt (0..2) and write each accepted tap into position tcnt, then advance tcnt, wrapping from 2 to 0.
REQ-015 SHALL clear filt_loaded on an accepted tap at tcnt=0 and set it on an accepted tap at tcnt=2.
REQ-016 SHALL let filter loading and sample loading proceed in the same cycle without interaction.
REQ-017 SHALL, when cnt=12 and filt_loaded=0, keep in_ready low and win_valid low until the filter completes; win_valid then rises in the cycle after the third tap is accepted.
REQ-018 SHALL ignore in_data, in_first and filt_data whenever the matching handshake does not occur.
REQ-019 SHALL have a latency of one cycle from acceptance of the 12th sample to win_valid high, given filt_loaded=1.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously force: cnt=0, tcnt=0, win_data=0, filter=0, filt_loaded=0, win_valid=0, in_ready=1, filt_ready=1.
REQ-021 SHALL, on a reset asserted mid-window or mid-filter-load, lose all partial data; after release, loading restarts from EMPTY and tap 0.
REQ-022 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-023 Basic window: load taps 1,2,3, then 12 samples 0,1,2,3,0,1,2,3,0,1,2,3 with win_ready=0 -> filter=6'b111001, win_valid=1, win_data=24'hE4E4E4, in_ready=0.
REQ-024 Overlap: from REQ-023 state, pulse win_ready for 1 cycle -> cnt=2, win_data=24'h00000E, win_valid=0; 10 further samples of value 1 -> win_data=24'h55555E, win_valid=1.
REQ-025 Filter gating: 12 samples loaded with no filter -> win_valid=0, in_ready=0; taps 3,0,1 -> win_valid=1 one cycle after the third tap, filter=6'b010011.
REQ-026 Row restart: 7 samples loaded, then a sample of value 2 with in_first=1 -> cnt=1, slot 0=2, slots 1..11=0.
REQ-027 Filter lock: filt_valid held high while win_valid=1 -> filt_ready=0 and filter unchanged; after the handshake a new 3-tap load clears filt_loaded on its first tap and sets it on its third.
REQ-028 Mid-operation reset: rst_n pulled low asynchronously with cnt=9 and tcnt=1 -> all outputs at REQ-020 values before the next clk edge; a full 12-sample load is then required for win_valid.

Source files
------------

// File: rtl/pe_window_loader.sv
// pe_window_loader: gathers 2-bit samples into a 12-sample window and
// a 3-tap filter, and presents both to a processing element. Consecutive
// windows overlap by two samples so a 3-tap convolution runs without gaps
// across window boundaries.
module pe_window_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  in_data,
    input  logic        in_first,
    output logic        in_ready,
    input  logic        filt_valid,
    input  logic [1:0]  filt_data,
    output logic        filt_ready,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [23:0] win_data,
    output logic [5:0]  filter,
    output logic        filt_loaded
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [23:0] r_win;
    logic [23:0] w_win_next;

    logic [1:0]  r_tcnt;
    logic [1:0]  r_tap [0:2];
    logic        r_filt_loaded;

    logic        w_smp_acc;
    logic        w_tap_acc;
    logic        w_win_hs;

    // The window state alone decides readiness; there is no bypass while full.
    assign in_ready    = (r_state != ST_FULL);
    assign win_valid   = (r_state == ST_FULL) && r_filt_loaded;
    assign filt_ready  = !win_valid;
    assign filt_loaded = r_filt_loaded;
    assign win_data    = r_win;

    assign w_smp_acc = in_valid && in_ready;
    assign w_tap_acc = filt_valid && filt_ready;
    assign w_win_hs  = win_valid && win_ready;

    // Pack the tap registers into the presented filter word.
    for (genvar gi = 0; gi < 3; gi++) begin : g_filter
        assign filter[2*gi +: 2] = r_tap[gi];
    end

    // Next window contents, fill count and fill state.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_win_next   = r_win;
        if (w_win_hs) begin
            // Keep the last two samples as the head of the next window.
            w_win_next   = {20'd0, r_win[23:20]};
            w_cnt_next   = 4'd2;
            w_state_next = ST_FILL;
        end else if (w_smp_acc) begin
            if (in_first) begin
                // New row: previous partial window is meaningless.
                w_win_next = {22'd0, in_data};
                w_cnt_next = 4'd1;
            end else begin
                w_win_next[{r_cnt, 1'b0} +: 2] = in_data;
                w_cnt_next = r_cnt + 4'd1;
            end
            w_state_next = (w_cnt_next == 4'd12) ? ST_FULL : ST_FILL;
        end
    end

    // Window state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_cnt   <= 4'd0;
            r_win   <= 24'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_win   <= w_win_next;
        end
    end

    // Filter tap loading; a new load invalidates the filter until tap 2 lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt        <= 2'd0;
            r_filt_loaded <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_tap[i] <= 2'd0;
            end
        end else if (w_tap_acc) begin
            r_tap[r_tcnt] <= filt_data;
            if (r_tcnt == 2'd0) begin
                r_filt_loaded <= 1'b0;
            end
            if (r_tcnt == 2'd2) begin
                r_filt_loaded <= 1'b1;
                r_tcnt        <= 2'd0;
            end else begin
                r_tcnt <= r_tcnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_pe_window_loader.sv
// Testbench for pe_window_loader: directed scenarios followed by random
// traffic, all compared against a queue-based model of the window.
module tb_pe_window_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_data;
    logic        in_first;
    logic        in_ready;
    logic        filt_valid;
    logic [1:0]  filt_data;
    logic        filt_ready;
    logic        win_valid;
    logic        win_ready;
    logic [23:0] win_data;
    logic [5:0]  filter;
    logic        filt_loaded;

    pe_window_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_first    (in_first),
        .in_ready    (in_ready),
        .filt_valid  (filt_valid),
        .filt_data   (filt_data),
        .filt_ready  (filt_ready),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_data    (win_data),
        .filter      (filter),
        .filt_loaded (filt_loaded)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_fail  = 0;
    int n_win   = 0;

    // Reference model: the window is simply the list of held samples.
    int       m_q[$];
    bit [1:0] m_taps[3];
    int       m_t;
    bit       m_loaded;

    function automatic logic [23:0] m_win();
        logic [23:0] w = '0;
        for (int k = 0; k < m_q.size(); k++) w[2*k +: 2] = 2'(m_q[k]);
        return w;
    endfunction

    function automatic logic [5:0] m_filter();
        return {m_taps[2], m_taps[1], m_taps[0]};
    endfunction

    function automatic bit m_wv();
        return (m_q.size() == 12) && m_loaded;
    endfunction

    task automatic m_reset();
        m_q.delete();
        for (int i = 0; i < 3; i++) m_taps[i] = 2'd0;
        m_t = 0;
        m_loaded = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("win_data",    32'(win_data),    32'(m_win()));
        chk("filter",      32'(filter),      32'(m_filter()));
        chk("win_valid",   32'(win_valid),   32'(m_wv()));
        chk("in_ready",    32'(in_ready),    32'(m_q.size() < 12));
        chk("filt_ready",  32'(filt_ready),  32'(!m_wv()));
        chk("filt_loaded", 32'(filt_loaded), 32'(m_loaded));
    endtask

    // One clock cycle: drive at negedge, check, then apply the model at posedge.
    task automatic cycle(input bit iv, input bit [1:0] id, input bit fst,
                         input bit fv, input bit [1:0] fd, input bit wr);
        bit wv, acc_s, acc_f;
        @(negedge clk);
        in_valid   = iv;
        in_data    = iv ? id : 2'($urandom);
        in_first   = iv ? fst : 1'($urandom);
        filt_valid = fv;
        filt_data  = fv ? fd : 2'($urandom);
        win_ready  = wr;
        #1 check_all();
        wv    = m_wv();
        acc_s = iv && (m_q.size() < 12);
        acc_f = fv && !wv;
        @(posedge clk);
        if (wv && wr) begin
            n_win++;
            $display("window %0d: data=%06h filter=%02h", n_win, m_win(), m_filter());
            m_q = '{m_q[10], m_q[11]};
        end
        if (acc_s) begin
            if (fst) m_q = '{int'(id)};
            else     m_q.push_back(int'(id));
        end
        if (acc_f) begin
            m_taps[m_t] = fd;
            if (m_t == 0) m_loaded = 1'b0;
            if (m_t == 2) m_loaded = 1'b1;
            m_t = (m_t + 1) % 3;
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_data = 0; in_first = 0;
        filt_valid = 0; filt_data = 0; win_ready = 0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        @(posedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all();
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_filt_ready", 32'(filt_ready), 32'd1);
        chk("rst_win_valid",  32'(win_valid),  32'd0);
        chk("rst_win_data",   32'(win_data),   32'd0);
        chk("rst_filter",     32'(filter),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("reset_in_ready",    32'(in_ready),    32'd1);
        chk("reset_filt_ready",  32'(filt_ready),  32'd1);
        chk("reset_win_valid",   32'(win_valid),   32'd0);
        chk("reset_win_data",    32'(win_data),    32'd0);
        chk("reset_filter",      32'(filter),      32'd0);
        chk("reset_filt_loaded", 32'(filt_loaded), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic window: taps 1,2,3 then samples 0,1,2,3 repeated.
        cycle(0, 0, 0, 1, 2'd1, 0);
        cycle(0, 0, 0, 1, 2'd2, 0);
        cycle(0, 0, 0, 1, 2'd3, 0);
        for (int k = 0; k < 12; k++) cycle(1, 2'(k % 4), 0, 0, 0, 0);
        #1;
        chk("basic_filter",    32'(filter),    32'b111001);
        chk("basic_win_valid", 32'(win_valid), 32'd1);
        chk("basic_win_data",  32'(win_data),  32'hE4E4E4);
        chk("basic_in_ready",  32'(in_ready),  32'd0);

        // Filter is locked while a window is presented.
        cycle(0, 0, 0, 1, 2'd0, 0);
        cycle(0, 0, 0, 1, 2'd0, 0);
        #1;
        chk("lock_filter",     32'(filter),     32'b111001);
        chk("lock_filt_ready", 32'(filt_ready), 32'd0);

        // Overlap: handshake keeps slots 10,11 as slots 0,1.
        cycle(0, 0, 0, 0, 0, 1);
        #1;
        chk("ovl_win_data",  32'(win_data),  32'h00000E);
        chk("ovl_win_valid", 32'(win_valid), 32'd0);
        for (int k = 0; k < 10; k++) cycle(1, 2'd1, 0, 0, 0, 0);
        #1;
        chk("ovl2_win_data",  32'(win_data),  32'h55555E);
        chk("ovl2_win_valid", 32'(win_valid), 32'd1);

        // New filter load after the handshake.
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 2'd2, 0);
        #1;
        chk("reload_first_tap", 32'(filt_loaded), 32'd0);
        cycle(0, 0, 0, 1, 2'd2, 0);
        cycle(0, 0, 0, 1, 2'd2, 0);
        #1;
        chk("reload_third_tap", 32'(filt_loaded), 32'd1);
        chk("reload_filter",    32'(filter),      32'b101010);

        // Row restart after 7 held samples.
        for (int k = 0; k < 5; k++) cycle(1, 2'd3, 0, 0, 0, 0);
        cycle(1, 2'd2, 1, 0, 0, 0);
        #1;
        chk("restart_win_data", 32'(win_data), 32'h000002);

        // Filter gating: full window with no filter waits for taps.
        do_reset();
        for (int k = 0; k < 12; k++) cycle(1, 2'($urandom), 0, 0, 0, 0);
        #1;
        chk("gate_win_valid", 32'(win_valid), 32'd0);
        chk("gate_in_ready",  32'(in_ready),  32'd0);
        cycle(0, 0, 0, 1, 2'd3, 0);
        cycle(0, 0, 0, 1, 2'd0, 0);
        #1;
        chk("gate_two_taps", 32'(win_valid), 32'd0);
        cycle(0, 0, 0, 1, 2'd1, 0);
        #1;
        chk("gate_win_valid_after", 32'(win_valid), 32'd1);
        chk("gate_filter",          32'(filter),    32'b010011);

        // Mid-operation reset with cnt=9, tcnt=1.
        do_reset();
        cycle(0, 0, 0, 1, 2'd1, 0);
        for (int k = 0; k < 9; k++) cycle(1, 2'($urandom), 0, 0, 0, 0);
        do_reset();
        for (int t = 0; t < 3; t++) cycle(0, 0, 0, 1, 2'($urandom), 0);
        for (int k = 0; k < 11; k++) cycle(1, 2'($urandom), 0, 0, 0, 0);
        #1;
        chk("post_rst_11", 32'(win_valid), 32'd0);
        cycle(1, 2'($urandom), 0, 0, 0, 0);
        #1;
        chk("post_rst_12", 32'(win_valid), 32'd1);
        cycle(0, 0, 0, 0, 0, 1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(9, 0) < 7, 2'($urandom), $urandom_range(15, 0) == 0,
                  $urandom_range(9, 0) < 3, 2'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
